cash_request_controller: RTL and testbench

// - Upstream controller for a row of NUM_CELLS cash_data_cell instances. Accepts lookup/insert/delete

---
 rtl/cash_req_if.sv | 23 ++
 rtl/cash_request_controller.sv | 124 ++++++++++++
 tb/tb_cash_request_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cash_req_if.sv
// cash_req_if: request/response handshake bundle between a requester and cash_request_controller.
interface cash_req_if #(
  parameter int KEY_WIDTH = 16,
  parameter int VALUE_WIDTH = 16
);
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [KEY_WIDTH-1:0] req_key;
  logic [VALUE_WIDTH-1:0] req_value;
  logic resp_valid;
  logic resp_ready;
  logic [1:0] resp_status;
  logic [VALUE_WIDTH-1:0] resp_value;
  modport master (
    output req_valid, req_op, req_key, req_value, resp_ready,
    input req_ready, resp_valid, resp_status, resp_value
  );
  modport slave (
    input req_valid, req_op, req_key, req_value, resp_ready,
    output req_ready, resp_valid, resp_status, resp_value
  );
endinterface

// File: rtl/cash_request_controller.sv
// cash_request_controller: linear-probing lookup/insert/delete controller for a row of cash cells.
// Defining CASH_CTRL_OCCUPANCY_EN adds a registered occupancy (popcount of occupied slots) output.
module cash_request_controller #(
  parameter int KEY_WIDTH = 16,
  parameter int VALUE_WIDTH = 16,
  parameter int NUM_CELLS = 8,
  localparam int IDX_W = $clog2(NUM_CELLS),
  localparam int DW = KEY_WIDTH + VALUE_WIDTH
) (
  input  logic clk,
  input  logic reset,
  cash_req_if.slave bus,
  output logic [NUM_CELLS-1:0] cell_cs,
  output logic cell_we,
  output logic cell_del,
  output logic [DW-1:0] cell_data_in,
  input  logic [NUM_CELLS*DW-1:0] cell_data_out
`ifdef CASH_CTRL_OCCUPANCY_EN
  ,
  output logic [IDX_W:0] occupancy
`endif
);
  typedef enum logic [1:0] {IDLE, PROBE, WRITE, RESP} state_t;
  localparam logic [1:0] OP_LOOKUP = 2'b00, OP_INSERT = 2'b01, OP_DELETE = 2'b10, OP_BAD = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_BAD = 2'b11;
  state_t state, state_n;
  logic [1:0] op, status;
  logic [KEY_WIDTH-1:0] key;
  logic [VALUE_WIDTH-1:0] value, rvalue;
  logic [IDX_W-1:0] idx, cnt, fe_idx;
  logic fe_valid;
  logic [NUM_CELLS-1:0] occupied;
  logic [DW-1:0] cur;
  logic match, last, fe_any;
  assign cur = cell_data_out[idx*DW +: DW];
  assign match = occupied[idx] && cur[DW-1:VALUE_WIDTH] == key;
  assign last = &cnt;
  // The slot under the final probe can itself be the first hole.
  assign fe_any = fe_valid || !occupied[idx];
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_status = status;
  assign bus.resp_value = rvalue;
  always_comb begin
    state_n = state;
    cell_cs = '0;
    cell_we = 1'b0;
    cell_del = 1'b0;
    cell_data_in = {key, value};
    case (state)
      IDLE: if (bus.req_valid) state_n = bus.req_op == OP_BAD ? RESP : PROBE;
      PROBE:
        if (match) begin
          state_n = RESP;
          cell_cs[idx] = op != OP_LOOKUP;
          cell_we = op == OP_INSERT;
          cell_del = op == OP_DELETE;
        end else if (last) state_n = op == OP_INSERT && fe_any ? WRITE : RESP;
      WRITE: begin
        state_n = RESP;
        cell_cs[fe_idx] = 1'b1;
        cell_we = 1'b1;
      end
      RESP: if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      key <= '0;
      value <= '0;
      idx <= '0;
      cnt <= '0;
      fe_idx <= '0;
      fe_valid <= 1'b0;
      occupied <= '0;
      status <= '0;
      rvalue <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE:
          if (bus.req_valid) begin
            op <= bus.req_op;
            key <= bus.req_key;
            value <= bus.req_value;
            idx <= bus.req_key[IDX_W-1:0] ^ bus.req_key[2*IDX_W-1:IDX_W];
            cnt <= '0;
            fe_valid <= 1'b0;
            status <= ST_BAD;
            rvalue <= '0;
          end
        PROBE:
          if (match) begin
            status <= ST_OK;
            rvalue <= op == OP_LOOKUP ? cur[VALUE_WIDTH-1:0] : '0;
            if (op == OP_DELETE) occupied[idx] <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
            cnt <= cnt + 1'b1;
            if (!fe_valid && !occupied[idx]) begin
              fe_valid <= 1'b1;
              fe_idx <= idx;
            end
            status <= op == OP_INSERT ? (fe_any ? ST_OK : ST_FULL) : ST_MISS;
          end
        WRITE: begin
          occupied[fe_idx] <= 1'b1;
          status <= ST_OK;
        end
        default: ;
      endcase
    end
  end
`ifdef CASH_CTRL_OCCUPANCY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occupancy <= '0;
    else if (state == WRITE) occupancy <= occupancy + 1'b1;
    else if (state == PROBE && match && op == OP_DELETE) occupancy <= occupancy - 1'b1;
  end
`endif
endmodule

// File: tb/tb_cash_request_controller.sv
// tb_cash_request_controller: directed and randomized checks of cash_request_controller against a slot-table model.
module tb_cash_request_controller;
  localparam int N = 8, KW = 16, VW = 16, DW = 32;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  cash_req_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();
  logic [N-1:0] cell_cs;
  logic cell_we, cell_del;
  logic [DW-1:0] cell_data_in;
  logic [N*DW-1:0] cell_data_out;
`ifdef CASH_CTRL_OCCUPANCY_EN
  logic [3:0] occupancy;
`endif
  cash_request_controller #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_CELLS(N)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .cell_cs(cell_cs),
    .cell_we(cell_we),
    .cell_del(cell_del),
    .cell_data_in(cell_data_in),
    .cell_data_out(cell_data_out)
`ifdef CASH_CTRL_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );
  logic [DW-1:0] mem [N];
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (reset) mem[i] <= '0;
      else if (cell_cs[i] && cell_we) mem[i] <= cell_data_in;
      else if (cell_cs[i] && cell_del) mem[i] <= '0;
  for (genvar g = 0; g < N; g++) begin : g_cell
    assign cell_data_out[g*DW +: DW] = mem[g];
  end
  int total = 0, bad = 0;
  logic [KW-1:0] mk [N];
  logic [VW-1:0] mv [N];
  logic mo [N];
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mo[i] = 1'b0;
      mk[i] = '0;
      mv[i] = '0;
    end
  endtask
  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mo[i]);
    return c;
  endfunction
  task automatic do_op(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                       input int hold, output int lat, output logic [1:0] st, output logic [VW-1:0] val);
    int h, found, fe, slot, exp_lat, s_cyc, s_cell;
    logic s_we, s_del;
    logic [1:0] exp_st;
    logic [VW-1:0] exp_val;
    logic [N-1:0] oh;
    h = (int'(k) % N) ^ ((int'(k) / N) % N);
    found = -1;
    fe = -1;
    slot = 0;
    for (int j = 0; j < N; j++) begin
      int s = (h + j) % N;
      if (found < 0 && mo[s] && mk[s] == k) begin
        found = j;
        slot = s;
      end
      if (found < 0 && fe < 0 && !mo[s]) fe = s;
    end
    exp_val = '0;
    s_cyc = 0;
    s_cell = 0;
    s_we = 1'b0;
    s_del = 1'b0;
    if (op == 2'b11) begin
      exp_st = 2'b11;
      exp_lat = 1;
    end else if (found >= 0) begin
      exp_st = 2'b00;
      exp_lat = found + 2;
      if (op == 2'b00) exp_val = mv[slot];
      else begin
        s_cyc = found + 1;
        s_cell = slot;
        s_we = op == 2'b01;
        s_del = op == 2'b10;
      end
    end else if (op == 2'b01 && fe >= 0) begin
      exp_st = 2'b00;
      exp_lat = N + 2;
      s_cyc = N + 1;
      s_cell = fe;
      s_we = 1'b1;
    end else begin
      exp_st = op == 2'b01 ? 2'b10 : 2'b01;
      exp_lat = N + 1;
    end
    @(negedge clk);
    chk("idle_ready", {bus.req_ready, bus.resp_valid}, 2'b10);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_key = k;
    bus.req_value = v;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom);
    bus.req_key = 16'($urandom);
    bus.req_value = 16'($urandom);
    lat = 0;
    for (int c = 1; c <= N + 4 && lat == 0; c++) begin
      @(negedge clk);
      oh = c == s_cyc ? N'(1) << s_cell : '0;
      chk("cycle_outputs", {bus.resp_valid, bus.req_ready, cell_cs, cell_we, cell_del},
          {c == exp_lat, 1'b0, oh, c == s_cyc && s_we, c == s_cyc && s_del});
      if (c == s_cyc && s_we) chk("cell_data_in", cell_data_in, {k, v});
      if (bus.resp_valid) lat = c;
    end
    chk("latency", lat, exp_lat);
    chk("resp_status", bus.resp_status, exp_st);
    chk("resp_value", bus.resp_value, exp_val);
    st = bus.resp_status;
    val = bus.resp_value;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("resp_hold", {bus.resp_valid, bus.req_ready, bus.resp_status, bus.resp_value, cell_cs},
          {1'b1, 1'b0, exp_st, exp_val, N'(0)});
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    if (op == 2'b01 && found >= 0) mv[slot] = v;
    else if (op == 2'b01 && fe >= 0) begin
      mo[fe] = 1'b1;
      mk[fe] = k;
      mv[fe] = v;
    end else if (op == 2'b10 && found >= 0) mo[slot] = 1'b0;
`ifdef CASH_CTRL_OCCUPANCY_EN
    chk("occupancy", occupancy, model_count());
`endif
  endtask
  initial begin
    int lat;
    logic [1:0] st;
    logic [VW-1:0] val;
    bus.req_valid = 0;
    bus.req_op = 0;
    bus.req_key = 0;
    bus.req_value = 0;
    bus.resp_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {bus.resp_valid, bus.req_ready, bus.resp_status, bus.resp_value, cell_cs, cell_we, cell_del},
        {1'b0, 1'b1, 2'b00, 16'h0, 8'h0, 1'b0, 1'b0});
    reset = 0;
    do_op(2'b01, 16'h0003, 16'h00AA, 0, lat, st, val);
    chk("ins3_lat", lat, 10);
    chk("ins3_cell", mem[3], 32'h000300AA);
    do_op(2'b00, 16'h0003, 16'h0, 0, lat, st, val);
    chk("look3", {lat[7:0], st, val}, {8'd2, 2'b00, 16'h00AA});
    do_op(2'b01, 16'h0018, 16'h0055, 0, lat, st, val);
    chk("ins18_cell", mem[4], 32'h00180055);
    do_op(2'b10, 16'h0003, 16'h0, 0, lat, st, val);
    chk("del3", {lat[7:0], st}, {8'd2, 2'b00});
    do_op(2'b00, 16'h0018, 16'h0, 0, lat, st, val);
    chk("look18", {lat[7:0], st, val}, {8'd3, 2'b00, 16'h0055});
    do_op(2'b00, 16'h0077, 16'h0, 0, lat, st, val);
    chk("look_miss", {lat[7:0], st}, {8'd9, 2'b01});
    do_op(2'b10, 16'h0077, 16'h0, 0, lat, st, val);
    chk("del_miss", {lat[7:0], st}, {8'd9, 2'b01});
    do_op(2'b11, 16'h1234, 16'h0, 0, lat, st, val);
    chk("bad_op", {lat[7:0], st}, {8'd1, 2'b11});
    do_op(2'b00, 16'h0018, 16'h0, 5, lat, st, val);
    for (int i = 0; i < 7; i++) do_op(2'b01, 16'(16'h0100 + i), 16'(16'h0A00 + i), 0, lat, st, val);
    chk("filled", model_count(), 8);
    do_op(2'b01, 16'h0200, 16'hBEEF, 0, lat, st, val);
    chk("full", {lat[7:0], st}, {8'd9, 2'b10});
    do_op(2'b01, 16'h0018, 16'h0099, 0, lat, st, val);
    chk("overwrite_cell", mem[4], 32'h00180099);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b00;
    bus.req_key = 16'h0300;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1;
    #1;
    chk("reset_mid_probe", {bus.resp_valid, bus.req_ready, cell_cs}, {1'b0, 1'b1, 8'h0});
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_clear();
    do_op(2'b00, 16'h0018, 16'h0, 0, lat, st, val);
    chk("miss_after_reset", {lat[7:0], st}, {8'd9, 2'b01});
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 15);
      logic [1:0] op = r < 6 ? 2'b01 : r < 10 ? 2'b00 : r < 14 ? 2'b10 : 2'b11;
      do_op(op, 16'($urandom_range(0, 23) * 7), 16'($urandom), $urandom_range(0, 3), lat, st, val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
